jpeg_stream_arbiter: RTL and testbench
======================================

JPEG_STREAM_ARBITER -- requirements
Module: jpeg_stream_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning stream word width in bits; only 32 is supported.
REQ-002 SHALL have parameter WATCHDOG, default 1024, meaning idle-source cycles before a mid-image abort; legal range 2..2^16-1.
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have ports s0_data / s1_data, input, 32 each, meaning source words: a length header in bytes, then ceil(len/4) payload words.
REQ-006 SHALL have ports s0_valid / s1_valid, input, 1 each, meaning the source word is present.
REQ-007 SHALL have ports s0_stall / s1_stall, output, 1 each, meaning the source must hold its word.
REQ-008 SHALL have port m_data, output, 32, meaning the word sent to the JPEG preprocessor input.
REQ-009 SHALL have port m_valid, output, 1, meaning m_data is present.
REQ-010 SHALL have port m_stall, input, 1, meaning the preprocessor's upstream stall.
REQ-011 SHALL have port cur_src, output, 1, meaning the index of the granted source.
REQ-012 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.
REQ-013 SHALL have port abort_pulse, output, 1, meaning a one-cycle flag that a watchdog abort flush completed.

Function
REQ-014 A word SHALL transfer on a port in any cycle where valid=1 and stall=0 on that port.
REQ-015 The FSM SHALL have exactly the states IDLE, HDR, PAYLOAD, FLUSH and ZERO.
REQ-016 In IDLE the block SHALL hold both s*_stall=1 and m_valid=0.
REQ-017 In IDLE with any s*_valid=1, the block SHALL go to HDR next cycle and register cur_src, favouring the source that requested alone.
REQ-018 In IDLE with both s*_valid=1, the block SHALL grant !last_grant (round-robin).
REQ-019 In HDR and PAYLOAD the path SHALL be a zero-latency combinational pass-through: m_data=s[cur_src]_data, m_valid=s[cur_src]_valid, s[cur_src]_stall=m_stall; the other source's stall SHALL be held at 1.
REQ-020 In HDR, on a header transfer with len=0, the block SHALL forward the word (it resets the decoder), go to IDLE, and set last_grant<=cur_src.
REQ-021 In HDR, on a header transfer with len>0, the block SHALL load rem<=(len+3)>>2, computed at 33 bits so that len=0xFFFFFFFF gives 0x40000000, and go to PAYLOAD.
REQ-022 In PAYLOAD, each transfer SHALL decrement rem; a transfer with rem=1 SHALL go to IDLE and set last_grant<=cur_src.
REQ-023 The watchdog counter SHALL increment in HDR/PAYLOAD each cycle s[cur_src]_valid=0, clear on any transfer or state change, and hold while m_stall=1 with valid=1.
REQ-024 A watchdog count reaching WATCHDOG in HDR SHALL go to IDLE, forward nothing, and leave last_grant unchanged.
REQ-025 A watchdog count reaching WATCHDOG in PAYLOAD SHALL go to FLUSH.
REQ-026 In FLUSH the block SHALL drive m_valid=1, m_data=0 and both s*_stall=1; each cycle with m_stall=0 SHALL decrement rem, and the transfer at rem=1 SHALL go to ZERO.
REQ-027 In ZERO the block SHALL drive m_valid=1 and m_data=0; the cycle with m_stall=0 SHALL go to IDLE, assert abort_pulse for that one cycle, and set last_grant<=cur_src.
REQ-028 After an abort, the next word from the aborted source SHALL be treated as a header; resynchronisation is the source's duty.
REQ-029 Source valid changes in FLUSH and ZERO SHALL have no effect.
REQ-030 busy SHALL be 1 in every state except IDLE.

Reset
REQ-031 reset=0 SHALL immediately force IDLE, with s*_stall=1, m_valid=0, m_data=0, cur_src=0, busy=0, abort_pulse=0, rem=0, watchdog=0 and last_grant=1 (source 0 wins the first tie).
REQ-032 Reset mid-image SHALL discard all progress with no flush; the decoder SHALL be reset by the same system reset.
REQ-033 Reset deassertion SHALL be synchronised externally; no transfer SHALL occur in the first cycle after deassertion.

Verification
REQ-034 Single source: s0 sends header 10 and then 3 words with m_stall=0 -> exactly 4 words appear on m_data in order, the FSM returns to IDLE after the 4th word, and busy=0 next cycle.
REQ-035 Contention: s0 and s1 both valid from reset, each sending header 4 and 1 word -> s0's image completes first, then s1's; s1_stall=1 throughout s0's image.
REQ-036 Back-pressure: m_stall toggles 1/0 every cycle during a 16-byte image -> no word is lost or duplicated, the watchdog does not fire, and s0_stall mirrors m_stall.
REQ-037 Abort with WATCHDOG=8: header 20, 2 words, then s0_valid=0 -> after 8 idle cycles, 3 zero words then 1 zero word are emitted, abort_pulse=1 for one cycle, and the FSM returns to IDLE.
REQ-038 Boundaries: header 0 -> one word forwarded and IDLE; header 0xFFFFFFFF -> rem=0x40000000.
REQ-039 Async reset in PAYLOAD: reset=0 -> all outputs take their reset values immediately, and a new header is accepted after release.

Source files
------------

// File: rtl/jpeg_stream_arbiter.sv
// jpeg_stream_arbiter: two-source round-robin arbiter framing length-prefixed images into a JPEG preprocessor, with watchdog abort flush
module jpeg_stream_arbiter #(
  parameter int WIDTH    = 32,
  parameter int WATCHDOG = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] s0_data,
  input  logic             s0_valid,
  output logic             s0_stall,
  input  logic [WIDTH-1:0] s1_data,
  input  logic             s1_valid,
  output logic             s1_stall,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_stall,
  output logic             cur_src,
  output logic             busy,
  output logic             abort_pulse
);
  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, FLUSH, ZERO} state_t;
  localparam logic [15:0] WD_LIMIT = 16'(WATCHDOG);
  state_t state_q, state_d;
  logic cur_src_q, cur_src_d, last_grant_q, last_grant_d;
  logic [31:0] rem_q, rem_d;
  logic [15:0] wd_q, wd_d;
  logic pass, sel_valid, xfer;
  logic [WIDTH-1:0] sel_data;
  logic [32:0] hdr_sum;
  assign pass      = state_q == HDR || state_q == PAYLOAD;
  assign sel_valid = cur_src_q ? s1_valid : s0_valid;
  assign sel_data  = cur_src_q ? s1_data : s0_data;
  assign xfer      = pass && sel_valid && !m_stall;
  // 33-bit sum so a header of all ones rounds up without wrapping
  assign hdr_sum   = {1'b0, sel_data} + 33'd3;
  // state register with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cur_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
      rem_q        <= '0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      cur_src_q    <= cur_src_d;
      last_grant_q <= last_grant_d;
      rem_q        <= rem_d;
      wd_q         <= wd_d;
    end
  end
  // next-state: grant, framing counter and watchdog
  always_comb begin
    state_d      = state_q;
    cur_src_d    = cur_src_q;
    last_grant_d = last_grant_q;
    rem_d        = rem_q;
    wd_d         = wd_q;
    case (state_q)
      IDLE: if (s0_valid || s1_valid) begin
        state_d   = HDR;
        cur_src_d = (s0_valid && s1_valid) ? !last_grant_q : s1_valid;
        wd_d      = '0;
      end
      HDR, PAYLOAD: if (xfer) begin
        wd_d = '0;
        if (state_q == HDR) begin
          state_d      = sel_data == '0 ? IDLE : PAYLOAD;
          last_grant_d = sel_data == '0 ? cur_src_q : last_grant_q;
          rem_d        = sel_data == '0 ? rem_q : 32'(hdr_sum >> 2);
        end else begin
          rem_d        = rem_q - 32'd1;
          state_d      = rem_q == 32'd1 ? IDLE : PAYLOAD;
          last_grant_d = rem_q == 32'd1 ? cur_src_q : last_grant_q;
        end
      end else if (!sel_valid) begin
        wd_d = wd_q + 16'd1;
        if (wd_d == WD_LIMIT) begin
          wd_d    = '0;
          state_d = state_q == HDR ? IDLE : FLUSH;
        end
      end
      FLUSH: if (!m_stall) begin
        rem_d   = rem_q - 32'd1;
        state_d = rem_q == 32'd1 ? ZERO : FLUSH;
      end
      ZERO: if (!m_stall) begin
        state_d      = IDLE;
        last_grant_d = cur_src_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs: pass-through in HDR/PAYLOAD, zero fill in FLUSH/ZERO
  always_comb begin
    m_valid     = pass ? sel_valid : (state_q == FLUSH || state_q == ZERO);
    m_data      = pass ? sel_data : '0;
    s0_stall    = (pass && !cur_src_q) ? m_stall : 1'b1;
    s1_stall    = (pass && cur_src_q) ? m_stall : 1'b1;
    cur_src     = cur_src_q;
    busy        = state_q != IDLE;
    abort_pulse = state_q == ZERO && !m_stall;
  end
endmodule

// File: tb/tb_jpeg_stream_arbiter.sv
// tb_jpeg_stream_arbiter: directed checks of framing, arbitration, back-pressure, abort and reset
module tb_jpeg_stream_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] s0_data = '0, s1_data = '0, m_data;
  logic        s0_valid = 1'b0, s1_valid = 1'b0, s0_stall, s1_stall;
  logic        m_valid, m_stall = 1'b0, cur_src, busy, abort_pulse;
  int          n_chk = 0, n_fail = 0;
  int          idx;
  logic [31:0] bp [5] = '{32'd16, 32'hB0, 32'hB1, 32'hB2, 32'hB3};
  jpeg_stream_arbiter #(.WIDTH(32), .WATCHDOG(8)) dut (
    .clock(clock), .reset(reset),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_stall(s0_stall),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_stall(s1_stall),
    .m_data(m_data), .m_valid(m_valid), .m_stall(m_stall),
    .cur_src(cur_src), .busy(busy), .abort_pulse(abort_pulse)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_s0_stall"}, s0_stall, 1);
    check({tag, "_s1_stall"}, s1_stall, 1);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_cur_src"}, cur_src, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_abort"}, abort_pulse, 0);
    check({tag, "_rem"}, dut.rem_q, 0);
  endtask
  initial begin
    #12;
    check_reset_outputs("rst");
    @(negedge clock);
    reset = 1'b1;
    tick();
    // single source: header 10 then 3 payload words
    s0_valid = 1; s0_data = 32'd10;
    #3;
    check("idle_s0_stall", s0_stall, 1);
    check("idle_m_valid", m_valid, 0);
    tick();
    #3;
    check("hdr_busy", busy, 1);
    check("hdr_m_valid", m_valid, 1);
    check("hdr_m_data", m_data, 32'd10);
    check("hdr_s0_stall", s0_stall, 0);
    check("hdr_s1_stall", s1_stall, 1);
    tick();
    check("single_rem", dut.rem_q, 3);
    for (int i = 0; i < 3; i++) begin
      s0_data = 32'hA000 + i;
      #3;
      check("single_word", m_data, 32'hA000 + i);
      check("single_busy", busy, 1);
      tick();
    end
    s0_valid = 0;
    #3;
    check("single_done_busy", busy, 0);
    check("single_done_valid", m_valid, 0);
    // contention from reset: both valid, s0 wins first tie
    reset = 0;
    s0_valid = 1; s0_data = 32'd4;
    s1_valid = 1; s1_data = 32'd4;
    @(negedge clock);
    reset = 1;
    tick();
    #3;
    check("cont_cur_src0", cur_src, 0);
    check("cont_hdr0", m_data, 32'd4);
    check("cont_s1_stall_a", s1_stall, 1);
    tick();
    s0_data = 32'h5000;
    #3;
    check("cont_word0", m_data, 32'h5000);
    check("cont_s1_stall_b", s1_stall, 1);
    tick();
    s0_valid = 0;
    #3;
    check("cont_gap_busy", busy, 0);
    check("cont_gap_s1_stall", s1_stall, 1);
    tick();
    #3;
    check("cont_cur_src1", cur_src, 1);
    check("cont_hdr1", m_data, 32'd4);
    check("cont_s1_pass", s1_stall, 0);
    check("cont_s0_hold", s0_stall, 1);
    tick();
    s1_data = 32'h6000;
    #3;
    check("cont_word1", m_data, 32'h6000);
    tick();
    s1_valid = 0;
    #3;
    check("cont_done_busy", busy, 0);
    // back-pressure: m_stall toggles through a 16-byte image
    s0_valid = 1; s0_data = bp[0];
    tick();
    idx = 0;
    for (int c = 0; c < 40 && idx < 5; c++) begin
      m_stall = (c % 2) == 0;
      s0_data = bp[idx];
      #3;
      check("bp_stall_mirror", s0_stall, m_stall);
      check("bp_valid", m_valid, 1);
      check("bp_no_abort", abort_pulse, 0);
      if (!m_stall) begin
        check("bp_data", m_data, bp[idx]);
        idx++;
      end
      tick();
    end
    check("bp_count", idx, 5);
    s0_valid = 0; m_stall = 0;
    #3;
    check("bp_done_busy", busy, 0);
    // watchdog abort: header 20, 2 words, then source goes quiet
    s0_valid = 1; s0_data = 32'd20;
    tick();
    tick();
    check("abort_rem_load", dut.rem_q, 5);
    for (int i = 0; i < 2; i++) begin
      s0_data = 32'hC0 + i;
      #3;
      check("abort_word", m_data, 32'hC0 + i);
      tick();
    end
    s0_valid = 0;
    for (int i = 0; i < 8; i++) begin
      #3;
      check("abort_wait_busy", busy, 1);
      check("abort_wait_valid", m_valid, 0);
      tick();
    end
    s0_valid = 1; s0_data = 32'd0;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("flush_valid", m_valid, 1);
      check("flush_data", m_data, 0);
      check("flush_s0_stall", s0_stall, 1);
      check("flush_abort", abort_pulse, 0);
      tick();
    end
    m_stall = 1;
    #3;
    check("zero_stalled_valid", m_valid, 1);
    check("zero_stalled_abort", abort_pulse, 0);
    tick();
    m_stall = 0;
    #3;
    check("zero_data", m_data, 0);
    check("zero_abort", abort_pulse, 1);
    tick();
    #3;
    check("post_abort_busy", busy, 0);
    check("post_abort_pulse", abort_pulse, 0);
    // header 0 after abort: forwarded then back to IDLE
    tick();
    #3;
    check("hdr0_valid", m_valid, 1);
    check("hdr0_data", m_data, 0);
    check("hdr0_s0_stall", s0_stall, 0);
    tick();
    s0_valid = 0;
    #3;
    check("hdr0_done_busy", busy, 0);
    // maximum header on s1 then async reset mid-payload
    s1_valid = 1; s1_data = 32'hFFFF_FFFF;
    tick();
    #3;
    check("max_cur_src", cur_src, 1);
    tick();
    check("max_rem", dut.rem_q, 32'h4000_0000);
    s1_data = 32'h77;
    #2;
    check("pre_rst_busy", busy, 1);
    reset = 0;
    #1;
    check_reset_outputs("midrst");
    s1_valid = 0;
    @(negedge clock);
    reset = 1;
    s0_valid = 1; s0_data = 32'd4;
    tick();
    #3;
    check("rel_hdr_data", m_data, 32'd4);
    check("rel_cur_src", cur_src, 0);
    check("rel_busy", busy, 1);
    tick();
    s0_data = 32'h99;
    #3;
    check("rel_word", m_data, 32'h99);
    tick();
    s0_valid = 0;
    #3;
    check("rel_done_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
